// File: rtl/weight_pad_pingpong_loader.sv
// -----------------------------------------------------------------------------
// weight_pad_pingpong_loader
//
// Purpose:
//   PE weight loader. Packed weight beats (PACK words per beat) are queued in a
//   small input FIFO. They are unpacked one word per cycle into the write bank
//   of a double-buffered scratch pad. The PE array reads the other bank. When a
//   bank is filled and the read side is free (or released), the banks swap, so
//   loading layer N+1 overlaps compute of layer N.
//
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   load_start   pulse: start filling the write bank with weight_num words
//   weight_num   number of words to load (sampled on an accepted load_start)
//   in_data      packed beat; word k = in_data[DATA_WIDTH*(k+1)-1 -: DATA_WIDTH]
//   in_valid     beat valid; accepted when in_valid & in_ready
//   in_ready     input FIFO not full
//   rd_addr      PE read address into the read bank
//   rd_release   pulse: PE is done with the read bank
//   weight_out   read data, one cycle after rd_addr
//   bank_ready   read bank holds a complete weight set
//   load_busy    loader FSM is not idle
//   load_done    one-cycle pulse when a filled bank swaps to the read side
//
// Configuration:
//   WPAD_ZERO_FILL_EN  when defined, each bank records its loaded word count at
//                      swap time, and reads at or beyond that count return 0.
// -----------------------------------------------------------------------------
module weight_pad_pingpong_loader #(
  parameter int DATA_WIDTH   = 16,
  parameter int PACK         = 4,
  parameter int FIFO_DEPTH_W = 2,
  parameter int ADDR_W       = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_start,
  input  logic [ADDR_W-1:0]          weight_num,
  input  logic [DATA_WIDTH*PACK-1:0] in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_W-1:0]          rd_addr,
  input  logic                       rd_release,
  output logic [DATA_WIDTH-1:0]      weight_out,
  output logic                       bank_ready,
  output logic                       load_busy,
  output logic                       load_done
);

  localparam int BEAT_W = DATA_WIDTH * PACK;
  localparam int DEPTH  = 1 << FIFO_DEPTH_W;
  localparam int K_W    = (PACK > 1) ? $clog2(PACK) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_UNPACK,
    S_FULL
  } state_t;

  state_t state;

  // ---------------------------------------------------------------------------
  // Input FIFO (pointers carry one extra wrap bit to tell full from empty)
  // ---------------------------------------------------------------------------
  logic [BEAT_W-1:0]       fifo_mem [DEPTH];
  logic [FIFO_DEPTH_W:0]   wr_ptr;
  logic [FIFO_DEPTH_W:0]   rd_ptr;
  logic                    fifo_empty;
  logic                    fifo_full;
  logic                    push;
  logic                    pop;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[FIFO_DEPTH_W] != rd_ptr[FIFO_DEPTH_W]) &&
                      (wr_ptr[FIFO_DEPTH_W-1:0] == rd_ptr[FIFO_DEPTH_W-1:0]);
  assign in_ready   = ~fifo_full;
  assign push       = in_valid & ~fifo_full;
  assign pop        = (state == S_WAIT) & ~fifo_empty;

  // NOTE: storage arrays have no reset; only the control state around them
  // does, so reset clears the FIFO by resetting its pointers.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[FIFO_DEPTH_W-1:0]] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Loader FSM
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] wn_q;    // latched weight_num
  logic [ADDR_W-1:0] addr;    // write address in the write bank
  logic [K_W-1:0]    k;       // word index inside the popped beat
  logic [BEAT_W-1:0] beat_q;  // beat being unpacked
  logic              wr_sel;  // bank being written; the other bank is read
`ifdef WPAD_ZERO_FILL_EN
  logic [ADDR_W-1:0] bank_count [2];
`endif

  assign load_busy = (state != S_IDLE);

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      wr_sel     <= 1'b0;
      bank_ready <= 1'b0;
      load_done  <= 1'b0;
      wn_q       <= '0;
      addr       <= '0;
      k          <= '0;
      beat_q     <= '0;
`ifdef WPAD_ZERO_FILL_EN
      bank_count[0] <= '0;
      bank_count[1] <= '0;
`endif
    end else begin
      load_done <= 1'b0;
      // A release outside FULL frees the read side; in FULL it triggers a swap.
      if (rd_release && bank_ready && state != S_FULL) bank_ready <= 1'b0;

      case (state)
        S_IDLE: begin
          if (load_start && weight_num != '0) begin
            wn_q  <= weight_num;
            addr  <= '0;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!fifo_empty) begin
            beat_q <= fifo_mem[rd_ptr[FIFO_DEPTH_W-1:0]];
            k      <= '0;
            state  <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          // Remaining words of the last beat are dropped once the count is met.
          if (addr == wn_q - 1'b1) begin
            state <= S_FULL;
          end else begin
            addr <= addr + 1'b1;
            if (k == K_W'(PACK - 1)) state <= S_WAIT;
            else                     k     <= k + 1'b1;
          end
        end
        S_FULL: begin
          if (!bank_ready || rd_release) begin
            wr_sel     <= ~wr_sel;
            bank_ready <= 1'b1;
            load_done  <= 1'b1;
            state      <= S_IDLE;
`ifdef WPAD_ZERO_FILL_EN
            bank_count[wr_sel] <= wn_q;
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Ping-pong scratch pad: bank select is the MSB of the address
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] pad [2**(ADDR_W+1)];

  always_ff @(posedge clk) begin
    if (state == S_UNPACK)
      pad[{wr_sel, addr}] <= beat_q[int'(k)*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      weight_out <= '0;
    end else begin
`ifdef WPAD_ZERO_FILL_EN
      if (rd_addr >= bank_count[~wr_sel]) weight_out <= '0;
      else                                weight_out <= pad[{~wr_sel, rd_addr}];
`else
      weight_out <= pad[{~wr_sel, rd_addr}];
`endif
    end
  end

endmodule

// File: tb/tb_weight_pad_pingpong_loader.sv
// -----------------------------------------------------------------------------
// tb_weight_pad_pingpong_loader
//
// Directed bench for weight_pad_pingpong_loader (DATA_WIDTH=16, PACK=4,
// FIFO_DEPTH_W=2, ADDR_W=8). Inputs are driven 1 time unit after each rising
// edge, and outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_weight_pad_pingpong_loader;

  localparam int DW = 16;
  localparam int PK = 4;
  localparam int AW = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           load_start;
  logic [AW-1:0]  weight_num;
  logic [DW*PK-1:0] in_data;
  logic           in_valid;
  logic           in_ready;
  logic [AW-1:0]  rd_addr;
  logic           rd_release;
  logic [DW-1:0]  weight_out;
  logic           bank_ready;
  logic           load_busy;
  logic           load_done;

  int checks   = 0;
  int failures = 0;
  int done_cnt;
  int acc_cnt;

  weight_pad_pingpong_loader #(
    .DATA_WIDTH(DW), .PACK(PK), .FIFO_DEPTH_W(2), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .weight_num(weight_num),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .rd_addr(rd_addr), .rd_release(rd_release), .weight_out(weight_out),
    .bank_ready(bank_ready), .load_busy(load_busy), .load_done(load_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Beat holding words base, base+1, base+2, base+3 (word 0 in the LSBs).
  function automatic logic [DW*PK-1:0] beat(input int base);
    logic [DW*PK-1:0] b;
    for (int j = 0; j < PK; j++) b[j*DW +: DW] = DW'(base + j);
    return b;
  endfunction

  // Run n cycles, counting load_done pulses.
  task automatic run_count(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      if (load_done) done_cnt++;
    end
  endtask

  initial begin
    rst = 1'b1; load_start = 1'b0; weight_num = '0; in_data = '0;
    in_valid = 1'b0; rd_addr = '0; rd_release = 1'b0;

    // Reset state
    step();
    check("rst_bank_ready", bank_ready, 0);
    check("rst_load_busy",  load_busy,  0);
    check("rst_load_done",  load_done,  0);
    check("rst_weight_out", weight_out, 0);
    check("rst_in_ready",   in_ready,   1);
    rst = 1'b0;
    step();

    // T1: three beats (words 0..11), weight_num=10
    in_valid = 1'b1;
    for (int b = 0; b < 3; b++) begin
      in_data = beat(4 * b);
      step();
    end
    in_valid = 1'b0;
    load_start = 1'b1; weight_num = 8'd10;
    step();
    load_start = 1'b0;
    check("t1_busy", load_busy, 1);
    done_cnt = 0;
    run_count(30);
    check("t1_done_once",  done_cnt,   1);
    check("t1_bank_ready", bank_ready, 1);
    check("t1_idle",       load_busy,  0);

    // T2: reads from bank 0
    rd_addr = 8'd7; step(); check("t2_rd7", weight_out, 7);
    rd_addr = 8'd0; step(); check("t2_rd0", weight_out, 0);
    rd_addr = 8'd9; step(); check("t2_rd9", weight_out, 9);
`ifdef WPAD_ZERO_FILL_EN
    rd_addr = 8'd12; step(); check("t2_rd12_zero", weight_out, 0);
    rd_addr = 8'd10; step(); check("t2_rd10_zero", weight_out, 0);
`endif

    // T3: second load (4 words) while read bank busy -> holds in FULL
    in_valid = 1'b1; in_data = beat(100);
    step();
    in_valid = 1'b0;
    load_start = 1'b1; weight_num = 8'd4;
    step();
    load_start = 1'b0;
    done_cnt = 0;
    run_count(20);
    check("t3_hold_no_done", done_cnt,   0);
    check("t3_hold_busy",    load_busy,  1);
    check("t3_hold_ready",   bank_ready, 1);
    rd_addr = 8'd2; step(); check("t3_old_bank_rd2", weight_out, 2);
    rd_release = 1'b1;
    step();
    rd_release = 1'b0;
    check("t3_swap_done",  load_done,  1);
    check("t3_swap_ready", bank_ready, 1);
    check("t3_swap_idle",  load_busy,  0);
    for (int a = 0; a < 4; a++) begin
      rd_addr = AW'(a);
      step();
      check("t3_new_data", weight_out, 100 + a);
    end
    check("t3_done_pulse_ends", load_done, 0);
`ifdef WPAD_ZERO_FILL_EN
    rd_addr = 8'd4; step(); check("t3_rd4_zero", weight_out, 0);
`endif

    // Release outside FULL clears bank_ready; a second release is ignored
    rd_release = 1'b1; step();
    check("rel_clears_ready", bank_ready, 0);
    step(); rd_release = 1'b0;
    check("rel_ignored", bank_ready, 0);

    // T6: weight_num=0 ignored; load_start while busy ignored
    done_cnt = 0;
    load_start = 1'b1; weight_num = 8'd0;
    step();
    if (load_done) done_cnt++;
    check("t6_zero_ignored", load_busy, 0);
    weight_num = 8'd4;
    step();
    check("t6_started", load_busy, 1);
    weight_num = 8'd8;             // re-start attempt while busy
    step();
    load_start = 1'b0;
    in_valid = 1'b1; in_data = beat(200);
    step();
    in_valid = 1'b0;
    run_count(20);
    check("t6_done_once", done_cnt,  1);
    check("t6_idle",      load_busy, 0);
    rd_addr = 8'd3; step(); check("t6_rd3", weight_out, 203);

    // T4: hold in_valid with no load -> exactly 4 beats accepted
    acc_cnt = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = beat(300 + 4 * i);
      if (in_ready) acc_cnt++;
      step();
    end
    in_valid = 1'b0;
    check("t4_accepted", acc_cnt,  4);
    check("t4_full",     in_ready, 0);

    // T5: reset during UNPACK at addr=5 (load_start edge + 7 cycles)
    load_start = 1'b1; weight_num = 8'd12;
    step();
    load_start = 1'b0;
    for (int i = 0; i < 7; i++) step();
    check("t5_mid_busy", load_busy, 1);
    rst = 1'b1;
    #1;
    check("t5_async_busy", load_busy, 0);
    step();
    check("t5_bank_ready", bank_ready, 0);
    check("t5_load_busy",  load_busy,  0);
    check("t5_in_ready",   in_ready,   1);
    check("t5_weight_out", weight_out, 0);
    rst = 1'b0;
    done_cnt = 0;
    run_count(10);
    check("t5_no_done_after", done_cnt, 0);
    check("t5_stays_idle",    load_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
